// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: mode codes, guard-band symbols, stage-1 record and
// the control / TERC4 / 8b->9b transition-minimising helpers.
package tmds_pkg;

  localparam logic [2:0] TMDS_MODE_CONTROL      = 3'd0;
  localparam logic [2:0] TMDS_MODE_VIDEO        = 3'd1;
  localparam logic [2:0] TMDS_MODE_VIDEO_GUARD  = 3'd2;
  localparam logic [2:0] TMDS_MODE_ISLAND       = 3'd3;
  localparam logic [2:0] TMDS_MODE_ISLAND_GUARD = 3'd4;

  localparam logic [9:0] TMDS_VGB_A      = 10'b1011001100;
  localparam logic [9:0] TMDS_VGB_B      = 10'b0100110011;
  localparam logic [9:0] TMDS_CTRL_RESET = 10'b1101010100;

  typedef struct packed {
    logic [2:0] mode;
    logic [1:0] cd;
    logic [3:0] did;
    logic [8:0] q_m;
  } tmds_s1_t;

  function automatic logic [9:0] tmds_ctrl(input logic [1:0] cd);
    logic [9:0] s;
    case (cd)
      2'b00:   s = 10'b1101010100;
      2'b01:   s = 10'b0010101011;
      2'b10:   s = 10'b0101010100;
      default: s = 10'b1010101011;
    endcase
    return s;
  endfunction

  function automatic logic [9:0] tmds_terc4(input logic [3:0] d);
    logic [9:0] s;
    case (d)
      4'h0: s = 10'b1010011100;
      4'h1: s = 10'b1001100011;
      4'h2: s = 10'b1011100100;
      4'h3: s = 10'b1011100010;
      4'h4: s = 10'b0101110001;
      4'h5: s = 10'b0100011110;
      4'h6: s = 10'b0110001110;
      4'h7: s = 10'b0100111100;
      4'h8: s = 10'b1011001100;
      4'h9: s = 10'b0100111001;
      4'hA: s = 10'b0110011100;
      4'hB: s = 10'b1011000110;
      4'hC: s = 10'b1010001110;
      4'hD: s = 10'b1001110001;
      4'hE: s = 10'b0101100011;
      default: s = 10'b1011000011;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] tmds_ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // q_m[8] = 1 marks the XOR chain, 0 the XNOR chain.
  function automatic logic [8:0] tmds_qm(input logic [7:0] d);
    logic [8:0] q;
    logic       use_xnor;
    logic [3:0] n1;
    n1       = tmds_ones8(d);
    use_xnor = (n1 > 4'd4) || (n1 == 4'd4 && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8]     = ~use_xnor;
    return q;
  endfunction

endpackage

// File: rtl/tmds_encoder_array_if.sv
// Bus bundle between the timing generator (master) and the lane array (slave).
// TMDS_DISPARITY_STATUS_EN adds the per-lane running-disparity status field.
interface tmds_encoder_array_if #(parameter int NUM_CHANNELS = 3);
  logic [2:0]                  mode;
  logic [8*NUM_CHANNELS-1:0]   video_data;
  logic [4*NUM_CHANNELS-1:0]   data_island_data;
  logic [2*NUM_CHANNELS-1:0]   control_data;
  logic [10*NUM_CHANNELS-1:0]  tmds;
`ifdef TMDS_DISPARITY_STATUS_EN
  logic [5*NUM_CHANNELS-1:0]   disparity;

  modport master (output mode, video_data, data_island_data, control_data,
                  input  tmds, disparity);
  modport slave  (input  mode, video_data, data_island_data, control_data,
                  output tmds, disparity);
`else
  modport master (output mode, video_data, data_island_data, control_data,
                  input  tmds);
  modport slave  (input  mode, video_data, data_island_data, control_data,
                  output tmds);
`endif
endinterface

// File: rtl/tmds_lane_encoder.sv
// One TMDS lane: stage 1 registers mode/side data and q_m, stage 2 picks the
// symbol and tracks running disparity. TMDS_DISPARITY_STATUS_EN exports cnt.
module tmds_lane_encoder
  import tmds_pkg::*;
#(
  parameter int LANE_SEL = 0
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [2:0] mode_i,
  input  logic [7:0] video_data_i,
  input  logic [3:0] island_data_i,
  input  logic [1:0] control_data_i,
  output logic [9:0] tmds_o
`ifdef TMDS_DISPARITY_STATUS_EN
  ,
  output logic signed [4:0] disparity_o
`endif
);

  tmds_s1_t s1_d, s1_q;

  always_comb begin
    s1_d.mode = mode_i;
    s1_d.cd   = control_data_i;
    s1_d.did  = island_data_i;
    s1_d.q_m  = tmds_qm(video_data_i);
  end

  // Reset parks stage 1 on control mode / cd=00 so the drain emits that code.
  always_ff @(posedge clk_pixel) begin
    if (reset) s1_q <= '0;
    else       s1_q <= s1_d;
  end

  logic [3:0]        n1, n0;
  logic signed [4:0] diff;
  logic              q8;
  logic [7:0]        qd;

  assign q8   = s1_q.q_m[8];
  assign qd   = s1_q.q_m[7:0];
  assign n1   = tmds_ones8(qd);
  assign n0   = 4'd8 - n1;
  assign diff = $signed({1'b0, n1}) - $signed({1'b0, n0});

  logic [9:0]        tmds_d, tmds_q;
  logic signed [4:0] cnt_d, cnt_q;

  always_comb begin
    tmds_d = '0;
    cnt_d  = '0;
    case (s1_q.mode)
      TMDS_MODE_CONTROL:     tmds_d = tmds_ctrl(s1_q.cd);
      TMDS_MODE_VIDEO: begin
        if (cnt_q == 5'sd0 || n1 == n0) begin
          tmds_d = {~q8, q8, q8 ? qd : ~qd};
          cnt_d  = q8 ? cnt_q + diff : cnt_q - diff;
        end else if ((cnt_q > 5'sd0 && n1 > n0) || (cnt_q < 5'sd0 && n0 > n1)) begin
          tmds_d = {1'b1, q8, ~qd};
          cnt_d  = cnt_q + (q8 ? 5'sd2 : 5'sd0) - diff;
        end else begin
          tmds_d = {1'b0, q8, qd};
          cnt_d  = cnt_q - (q8 ? 5'sd0 : 5'sd2) + diff;
        end
      end
      TMDS_MODE_VIDEO_GUARD:  tmds_d = (LANE_SEL == 1) ? TMDS_VGB_B : TMDS_VGB_A;
      TMDS_MODE_ISLAND:       tmds_d = tmds_terc4(s1_q.did);
      TMDS_MODE_ISLAND_GUARD: tmds_d = (LANE_SEL == 0) ? tmds_terc4({2'b11, s1_q.cd})
                                                       : TMDS_VGB_B;
      default:                tmds_d = '0;
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      tmds_q <= TMDS_CTRL_RESET;
      cnt_q  <= '0;
    end else begin
      tmds_q <= tmds_d;
      cnt_q  <= cnt_d;
    end
  end

  assign tmds_o = tmds_q;
`ifdef TMDS_DISPARITY_STATUS_EN
  assign disparity_o = cnt_q;
`endif

endmodule

// File: rtl/tmds_encoder_array.sv
// NUM_CHANNELS lock-step TMDS lanes sharing one mode select; 2-register latency.
// TMDS_DISPARITY_STATUS_EN exposes each lane's running disparity on the bus.
module tmds_encoder_array #(
  parameter int NUM_CHANNELS = 3
) (
  input  logic clk_pixel,
  input  logic reset,
  tmds_encoder_array_if.slave bus
);

  logic [NUM_CHANNELS-1:0][7:0] vd;
  logic [NUM_CHANNELS-1:0][3:0] did;
  logic [NUM_CHANNELS-1:0][1:0] cd;
  logic [NUM_CHANNELS-1:0][9:0] tmds_w;

  assign vd       = bus.video_data;
  assign did      = bus.data_island_data;
  assign cd       = bus.control_data;
  assign bus.tmds = tmds_w;

`ifdef TMDS_DISPARITY_STATUS_EN
  logic [NUM_CHANNELS-1:0][4:0] disp_w;
  assign bus.disparity = disp_w;
`endif

  // Guard-band flavour repeats every three lanes.
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_lane
    tmds_lane_encoder #(.LANE_SEL(c % 3)) u_lane (
      .clk_pixel      (clk_pixel),
      .reset          (reset),
      .mode_i         (bus.mode),
      .video_data_i   (vd[c]),
      .island_data_i  (did[c]),
      .control_data_i (cd[c]),
      .tmds_o         (tmds_w[c])
`ifdef TMDS_DISPARITY_STATUS_EN
      ,
      .disparity_o    (disp_w[c])
`endif
    );
  end

endmodule

// File: tb/tb_tmds_encoder_array.sv
// Directed + model-checked random bench for tmds_encoder_array with 4 lanes.
// Disparity checks are compiled in when TMDS_DISPARITY_STATUS_EN is defined.
module tb_tmds_encoder_array;
  localparam int NC = 4;
  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] V00 = 10'b0100000000;
  localparam logic [9:0] V11 = 10'b1111111111;
  localparam logic [9:0] GA  = 10'b1011001100;
  localparam logic [9:0] GB  = 10'b0100110011;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  tmds_encoder_array_if #(.NUM_CHANNELS(NC)) bus ();
  tmds_encoder_array #(.NUM_CHANNELS(NC)) dut (.clk_pixel(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int lane, input logic [9:0] obs, input logic [9:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s lane %0d: observed %b expected %b", tag, lane, obs, exp);
    end
  endtask

  function automatic logic [9:0] lt(input int c);
    return bus.tmds[10*c +: 10];
  endfunction

`ifdef TMDS_DISPARITY_STATUS_EN
  function automatic logic [9:0] ld(input int c);
    return {5'b0, bus.disparity[5*c +: 5]};
  endfunction
  function automatic logic [9:0] dx(input int v);
    return {5'b0, 5'(v)};
  endfunction
`endif

  function automatic logic [9:0] ref_terc4(input logic [3:0] d);
    case (d)
      4'h0: return 10'b1010011100;  4'h1: return 10'b1001100011;
      4'h2: return 10'b1011100100;  4'h3: return 10'b1011100010;
      4'h4: return 10'b0101110001;  4'h5: return 10'b0100011110;
      4'h6: return 10'b0110001110;  4'h7: return 10'b0100111100;
      4'h8: return 10'b1011001100;  4'h9: return 10'b0100111001;
      4'hA: return 10'b0110011100;  4'hB: return 10'b1011000110;
      4'hC: return 10'b1010001110;  4'hD: return 10'b1001110001;
      4'hE: return 10'b0101100011;  default: return 10'b1011000011;
    endcase
  endfunction

  function automatic logic [9:0] ref_ctrl(input logic [1:0] cd);
    case (cd)
      2'b00: return 10'b1101010100;  2'b01: return 10'b0010101011;
      2'b10: return 10'b0101010100;  default: return 10'b1010101011;
    endcase
  endfunction

  // Inverse of the video coding: undo the optional inversion, then the chain.
  function automatic logic [7:0] dec(input logic [9:0] s);
    logic [7:0] d, o;
    d = s[9] ? ~s[7:0] : s[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  task automatic ref_enc(input int lane, input logic [2:0] m, input logic [7:0] d,
                         input logic [3:0] di, input logic [1:0] cd,
                         inout int cnt, output logic [9:0] o);
    logic [8:0] q;
    int n1d, n1, n0;
    bit xn;
    n1d = $countones(d);
    xn  = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? (q[i-1] ~^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = !xn;
    n1 = $countones(q[7:0]);
    n0 = 8 - n1;
    case (m)
      3'd0: o = ref_ctrl(cd);
      3'd1: begin
        if (cnt == 0 || n1 == n0) begin
          o = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
          cnt += q[8] ? n1 - n0 : n0 - n1;
        end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
          o = {1'b1, q[8], ~q[7:0]};
          cnt += (q[8] ? 2 : 0) + n0 - n1;
        end else begin
          o = {1'b0, q[8], q[7:0]};
          cnt += (q[8] ? 0 : -2) + n1 - n0;
        end
      end
      3'd2: o = (lane % 3 == 1) ? GB : GA;
      3'd3: o = ref_terc4(di);
      3'd4: o = (lane % 3 == 0) ? ref_terc4({2'b11, cd}) : GB;
      default: o = 10'd0;
    endcase
    if (m != 3'd1) cnt = 0;
  endtask

  task automatic rand_in();
    bus.video_data       = 32'($urandom());
    bus.data_island_data = 16'($urandom());
    bus.control_data     = 8'($urandom());
  endtask

  int         mcnt[NC];
  logic [9:0] exp_now[NC], exp_prev[NC];
  int         cnt_now[NC], cnt_prev[NC];
  logic [7:0] vd_now[NC], vd_prev[NC];
  bit         vid_prev, have_prev;

  initial begin
    // Reset with random inputs: control 00 from the first reset edge on.
    reset = 1'b1;
    bus.mode = 3'($urandom_range(0, 7));
    rand_in();
    for (int r = 0; r < 3; r++) begin
      tick();
      for (int c = 0; c < NC; c++) begin
        chk("reset_tmds", c, lt(c), C00);
`ifdef TMDS_DISPARITY_STATUS_EN
        chk("reset_disp", c, ld(c), 10'd0);
`endif
      end
      bus.mode = 3'($urandom_range(0, 7));
      rand_in();
    end

    // Video 0x00 stream: alternating symbols, cnt -8, +2, -6.
    reset = 1'b0;
    bus.mode = 3'd1; bus.video_data = '0; bus.control_data = '0;
    tick(); chk("lat_first", 0, lt(0), C00);
    tick(); chk("vid0_a", 0, lt(0), V00); chk("vid0_a", 3, lt(3), V00);
`ifdef TMDS_DISPARITY_STATUS_EN
    chk("vid0_a_disp", 0, ld(0), dx(-8));
`endif
    tick(); chk("vid0_b", 0, lt(0), V11);
`ifdef TMDS_DISPARITY_STATUS_EN
    chk("vid0_b_disp", 0, ld(0), dx(2));
`endif
    tick(); chk("vid0_c", 0, lt(0), V00);
`ifdef TMDS_DISPARITY_STATUS_EN
    chk("vid0_c_disp", 0, ld(0), dx(-6));
`endif
    // One control cycle clears cnt; the next 0x00 restarts the pattern.
    bus.mode = 3'd0;
    tick(); chk("clr_last_vid", 0, lt(0), V11);
    bus.mode = 3'd1;
    tick(); chk("clr_ctrl", 0, lt(0), C00);
`ifdef TMDS_DISPARITY_STATUS_EN
    chk("clr_disp", 0, ld(0), dx(0));
`endif
    tick(); chk("clr_restart", 0, lt(0), V00);

    // Video guard band.
    bus.mode = 3'd2;
    tick(); tick();
    chk("vgb", 0, lt(0), GA); chk("vgb", 1, lt(1), GB);
    chk("vgb", 2, lt(2), GA); chk("vgb", 3, lt(3), GA);
`ifdef TMDS_DISPARITY_STATUS_EN
    chk("vgb_disp", 0, ld(0), dx(0));
`endif

    // Island guard band: lane 0 cd=01, lane 3 cd=10.
    bus.mode = 3'd4; bus.control_data = 8'b10_11_00_01;
    tick(); tick();
    chk("igb", 0, lt(0), 10'b1001110001); chk("igb", 1, lt(1), GB);
    chk("igb", 2, lt(2), GB);             chk("igb", 3, lt(3), 10'b0101100011);

    // TERC4 data island: 0x0, 0xF, 0xD, 0x8.
    bus.mode = 3'd3; bus.data_island_data = 16'h8DF0;
    tick(); tick();
    chk("terc4", 0, lt(0), 10'b1010011100); chk("terc4", 1, lt(1), 10'b1011000011);
    chk("terc4", 2, lt(2), 10'b1001110001); chk("terc4", 3, lt(3), 10'b1011001100);

    // Reserved mode emits zeros.
    bus.mode = 3'd6;
    tick(); tick();
    for (int c = 0; c < NC; c++) chk("reserved", c, lt(c), 10'd0);

    // Control codes per lane.
    bus.mode = 3'd0; bus.control_data = 8'b11_10_01_00;
    tick(); tick();
    chk("ctrl", 0, lt(0), 10'b1101010100); chk("ctrl", 1, lt(1), 10'b0010101011);
    chk("ctrl", 2, lt(2), 10'b0101010100); chk("ctrl", 3, lt(3), 10'b1010101011);

    // Random stream, mostly video with back-to-back mode switches.
    for (int c = 0; c < NC; c++) mcnt[c] = 0;
    have_prev = 1'b0;
    vid_prev  = 1'b0;
    for (int t = 0; t < 10000; t++) begin
      logic [2:0] m;
      m = ($urandom_range(0, 9) < 8) ? 3'd1 : 3'($urandom_range(0, 7));
      bus.mode = m;
      for (int c = 0; c < NC; c++) begin
        logic [7:0] v; logic [3:0] di; logic [1:0] cd;
        v = 8'($urandom()); di = 4'($urandom()); cd = 2'($urandom());
        bus.video_data[8*c +: 8]       = v;
        bus.data_island_data[4*c +: 4] = di;
        bus.control_data[2*c +: 2]     = cd;
        ref_enc(c, m, v, di, cd, mcnt[c], exp_now[c]);
        cnt_now[c] = mcnt[c];
        vd_now[c]  = v;
      end
      tick();
      if (have_prev) begin
        for (int c = 0; c < NC; c++) begin
          chk("rand_tmds", c, lt(c), exp_prev[c]);
          if (vid_prev) chk("rand_decode", c, {2'b00, dec(lt(c))}, {2'b00, vd_prev[c]});
`ifdef TMDS_DISPARITY_STATUS_EN
          chk("rand_disp", c, ld(c), dx(cnt_prev[c]));
`endif
        end
      end
      for (int c = 0; c < NC; c++) begin
        exp_prev[c] = exp_now[c];
        cnt_prev[c] = cnt_now[c];
        vd_prev[c]  = vd_now[c];
      end
      vid_prev  = (m == 3'd1);
      have_prev = 1'b1;
    end

    // Reset in the middle of video discards in-flight symbols.
    bus.mode = 3'd1; rand_in(); reset = 1'b1;
    tick();
    for (int c = 0; c < NC; c++) chk("midreset", c, lt(c), C00);
    reset = 1'b0; bus.video_data = '0;
    tick(); chk("midreset_drain", 0, lt(0), C00);
    tick(); chk("midreset_first", 0, lt(0), V00);
`ifdef TMDS_DISPARITY_STATUS_EN
    chk("midreset_disp", 0, ld(0), dx(-8));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
